// File: rtl/dcm_adv_clkdiv_sequencer.sv
// Reset/lock sequencer for a DCM_ADV-style clock divider: holds the divider in
// reset, switches its divide mode, waits for feedback lock and retries on timeout.
module dcm_adv_clkdiv_sequencer #(
    parameter int HOLD_CYCLES   = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_EDGES    = 4,
    parameter int TIMEOUT       = 255,
    parameter int MAX_RETRY     = 3
) (
    input  logic clock,
    input  logic rst_reg,
    input  logic cfg_req,
    input  logic cfg_div2,
    input  logic fb_pulse,
    output logic div_rst,
    output logic div_clock_type,
    output logic cfg_ack,
    output logic locked,
    output logic busy,
    output logic err_fail
);

    localparam int CYC_MAX = (HOLD_CYCLES > SETTLE_CYCLES)
                           ? ((HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT)
                           : ((SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT);
    localparam int CW = $clog2(CYC_MAX + 1);
    localparam int EW = $clog2(LOCK_EDGES + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [EW-1:0] EDGE_LAST    = EW'(LOCK_EDGES - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_SETTLE,
        ST_LOCKING,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cyc_cnt_reg;
    logic [EW-1:0]   edge_cnt_reg;
    logic [RW-1:0]   retry_cnt_reg;
    logic            pend_div2_reg;
    logic            ack_pend_reg;

    logic accept;
    logic reseq;

    // A request is only taken in a stable state, and never in the cycle its own ack shows.
    always_comb begin
        accept = 1'b0;
        reseq  = 1'b0;
        if ((state_reg == ST_LOCKED || state_reg == ST_FAIL) && cfg_req && !cfg_ack) begin
            accept = 1'b1;
            reseq  = (state_reg == ST_FAIL) || (cfg_div2 != div_clock_type);
        end
    end

    always_ff @(posedge clock or negedge rst_reg) begin
        if (!rst_reg) begin
            state_reg      <= ST_ASSERT;
            cyc_cnt_reg    <= '0;
            edge_cnt_reg   <= '0;
            retry_cnt_reg  <= '0;
            pend_div2_reg  <= 1'b0;
            ack_pend_reg   <= 1'b0;
            div_rst        <= 1'b1;
            div_clock_type <= 1'b0;
            cfg_ack        <= 1'b0;
            locked         <= 1'b0;
            busy           <= 1'b1;
            err_fail       <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            case (state_reg)
                ST_ASSERT: begin
                    // Mode switches one cycle into reset so the divider never sees it live.
                    if (cyc_cnt_reg == '0) begin
                        div_clock_type <= pend_div2_reg;
                    end
                    if (cyc_cnt_reg == HOLD_LAST) begin
                        state_reg   <= ST_SETTLE;
                        cyc_cnt_reg <= '0;
                        div_rst     <= 1'b0;
                    end else begin
                        cyc_cnt_reg <= (&cyc_cnt_reg) ? cyc_cnt_reg : cyc_cnt_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cyc_cnt_reg == SETTLE_LAST) begin
                        state_reg    <= ST_LOCKING;
                        cyc_cnt_reg  <= '0;
                        edge_cnt_reg <= '0;
                    end else begin
                        cyc_cnt_reg <= (&cyc_cnt_reg) ? cyc_cnt_reg : cyc_cnt_reg + 1'b1;
                    end
                end
                ST_LOCKING: begin
                    // Lock is tested before timeout so a final edge on the last cycle still locks.
                    if (fb_pulse && edge_cnt_reg == EDGE_LAST) begin
                        state_reg    <= ST_LOCKED;
                        locked       <= 1'b1;
                        busy         <= 1'b0;
                        cfg_ack      <= ack_pend_reg;
                        ack_pend_reg <= 1'b0;
                    end else if (cyc_cnt_reg == TIMEOUT_LAST) begin
                        cyc_cnt_reg <= '0;
                        div_rst     <= 1'b1;
                        if (retry_cnt_reg == RETRY_LAST) begin
                            state_reg    <= ST_FAIL;
                            busy         <= 1'b0;
                            err_fail     <= 1'b1;
                            cfg_ack      <= ack_pend_reg;
                            ack_pend_reg <= 1'b0;
                        end else begin
                            state_reg     <= ST_ASSERT;
                            retry_cnt_reg <= (&retry_cnt_reg) ? retry_cnt_reg : retry_cnt_reg + 1'b1;
                        end
                    end else begin
                        cyc_cnt_reg <= (&cyc_cnt_reg) ? cyc_cnt_reg : cyc_cnt_reg + 1'b1;
                        if (fb_pulse) begin
                            edge_cnt_reg <= (&edge_cnt_reg) ? edge_cnt_reg : edge_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_LOCKED, ST_FAIL: begin
                    if (reseq) begin
                        state_reg     <= ST_ASSERT;
                        cyc_cnt_reg   <= '0;
                        retry_cnt_reg <= '0;
                        pend_div2_reg <= cfg_div2;
                        ack_pend_reg  <= 1'b1;
                        div_rst       <= 1'b1;
                        locked        <= 1'b0;
                        busy          <= 1'b1;
                        err_fail      <= 1'b0;
                    end else if (accept) begin
                        cfg_ack <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_ASSERT;
                    cyc_cnt_reg <= '0;
                    div_rst     <= 1'b1;
                    locked      <= 1'b0;
                    busy        <= 1'b1;
                    err_fail    <= 1'b0;
                end
            endcase
        end
    end

endmodule
